// File: rtl/wf_pkg.sv
// Shared types for the waveform controller: write/play FSM states and channel-width helper.
package wf_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_WRITE,
    W_DONE
  } wr_state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_RUN,
    P_DONE
  } play_state_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wf_play_seq.sv
// Playback sequencer: steps a shared read index on each sample tick, one-shot or looped.
module wf_play_seq
  import wf_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LOOP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic [ADDR_W-1:0] i_max_cnt,
  input  logic              i_tick,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_valid,
  output logic              o_wf_mode,
  output logic              o_done,
  output logic              o_aborted,
  output logic [LOOP_W-1:0] o_loop_cnt
);

  play_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_max, w_max_nxt;
  logic              r_loop, w_loop_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_mode, w_mode_nxt;
  logic              r_done, w_done_nxt;
  logic              r_aborted, w_aborted_nxt;
  logic [LOOP_W-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_max_nxt     = r_max;
    w_loop_nxt    = r_loop;
    w_rd_addr_nxt = r_rd_addr;
    w_valid_nxt   = 1'b0;
    w_mode_nxt    = r_mode;
    w_done_nxt    = 1'b0;
    w_aborted_nxt = r_aborted;
    w_cnt_nxt     = r_cnt;
    unique case (r_state)
      P_IDLE: begin
        if (i_start) begin
          w_state_nxt   = P_RUN;
          w_max_nxt     = i_max_cnt;
          w_loop_nxt    = i_loop;
          w_idx_nxt     = '0;
          w_cnt_nxt     = '0;
          w_aborted_nxt = 1'b0;
          w_mode_nxt    = 1'b1;
        end
      end
      P_RUN: begin
        // Stop takes priority over a coincident tick: no sample is issued.
        if (i_stop) begin
          w_state_nxt   = P_DONE;
          w_mode_nxt    = 1'b0;
          w_done_nxt    = 1'b1;
          w_aborted_nxt = 1'b1;
        end else if (i_tick) begin
          w_rd_addr_nxt = r_idx;
          w_valid_nxt   = 1'b1;
          if (r_idx < r_max) begin
            w_idx_nxt = r_idx + 1'b1;
          end else if (r_loop) begin
            w_idx_nxt = '0;
            if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
          end else begin
            w_state_nxt = P_DONE;
            w_mode_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      P_DONE: begin
        if (!i_start) w_state_nxt = P_IDLE;
      end
      default: w_state_nxt = P_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= P_IDLE;
      r_idx     <= '0;
      r_max     <= '0;
      r_loop    <= 1'b0;
      r_rd_addr <= '0;
      r_valid   <= 1'b0;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_max     <= w_max_nxt;
      r_loop    <= w_loop_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_valid   <= w_valid_nxt;
      r_mode    <= w_mode_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_aborted_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  assign o_rd_addr  = r_rd_addr;
  assign o_rd_valid = r_valid;
  assign o_wf_mode  = r_mode;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;
  assign o_loop_cnt = r_cnt;

endmodule

// File: rtl/wf_seq_ctrl.sv
// Multi-channel waveform controller: host write path into per-channel DPBRAMs plus playback sequencer.
module wf_seq_ctrl
  import wf_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LOOP_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [ch_w(CH_NUM)-1:0]  i_wr_ch,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  output logic [CH_NUM-1:0]        o_ram_we,
  output logic [ADDR_W-1:0]        o_ram_addr,
  output logic [DATA_W-1:0]        o_ram_din,
  output logic                     o_wr_err,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  input  logic [ADDR_W-1:0]        i_max_cnt,
  input  logic                     i_tick,
  output logic [ADDR_W-1:0]        o_rd_addr,
  output logic                     o_rd_valid,
  output logic                     o_wf_mode,
  output logic                     o_done,
  output logic                     o_aborted,
  output logic [LOOP_W-1:0]        o_loop_cnt
);

  localparam int CH_W = ch_w(CH_NUM);

  wr_state_e         r_wst, w_wst_nxt;
  logic [CH_W-1:0]   r_ch;
  logic [ADDR_W-1:0] r_addr, r_ram_addr;
  logic [DATA_W-1:0] r_data, r_ram_din;
  logic [CH_NUM-1:0] r_we;
  logic              r_err;
  logic              w_accept;
  logic              w_ch_ok;
  logic [CH_NUM-1:0] w_onehot;

  assign w_accept = (r_wst == W_IDLE) && i_wr_en;
  assign w_ch_ok  = 32'(r_ch) < CH_NUM;
  assign w_onehot = CH_NUM'(1) << r_ch;

  always_comb begin
    w_wst_nxt = r_wst;
    unique case (r_wst)
      W_IDLE:  if (i_wr_en) w_wst_nxt = W_SETUP;
      W_SETUP: w_wst_nxt = W_WRITE;
      W_WRITE: w_wst_nxt = W_DONE;
      W_DONE:  if (!i_wr_en) w_wst_nxt = W_IDLE;
      default: w_wst_nxt = W_IDLE;
    endcase
  end

  // Enable/err are registered on leaving SETUP so they are high during the WRITE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wst      <= W_IDLE;
      r_ch       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_we       <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wst <= w_wst_nxt;
      if (w_accept) begin
        r_ch   <= i_wr_ch;
        r_addr <= i_wr_addr;
        r_data <= i_wr_data;
      end
      if (r_wst == W_SETUP) begin
        r_ram_addr <= r_addr;
        r_ram_din  <= r_data;
      end
      r_we  <= (r_wst == W_SETUP && w_ch_ok) ? w_onehot : '0;
      r_err <= (r_wst == W_SETUP) && !w_ch_ok;
    end
  end

  assign o_ram_we   = r_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_wr_err   = r_err;

  wf_play_seq #(
    .ADDR_W(ADDR_W),
    .LOOP_W(LOOP_W)
  ) u_play (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_loop     (i_loop),
    .i_max_cnt  (i_max_cnt),
    .i_tick     (i_tick),
    .o_rd_addr  (o_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_wf_mode  (o_wf_mode),
    .o_done     (o_done),
    .o_aborted  (o_aborted),
    .o_loop_cnt (o_loop_cnt)
  );

endmodule
